pc_fetch: RTL
=============

Name: pc_fetch

Overview:
- Program-counter and instruction-fetch sequencer for the single-cycle RISC-V core.
- Holds the architectural PC and drives it to the PC+4 adder and the branch-target adder.
- Consumes those adder results to select the next PC.
- Runs a request/acknowledge handshake with instruction memory and presents each fetched instruction to decode with a valid flag.

Parameters:
- RESET_VECTOR, 32'h00000000: PC value loaded on reset.
- NOP_INSTR, 32'h00000013: value of instr_out while no valid instruction is held (addi x0,x0,0).

Ports:
- clk_in  input  1  system clock, rising-edge active
- rst_in  input  1  reset, asynchronous, active-high
- pc_plus4_in  input  32  pc_out + 4 from the adder (carry discarded)
- branch_target_in  input  32  redirect target from the target adder
- branch_taken_in  input  1  select branch_target_in as next PC
- stall_in  input  1  hold the current instruction; PC does not advance
- imem_ack_in  input  1  instruction memory returns imem_data_in this cycle
- imem_data_in  input  32  fetched instruction word
- pc_out  output  32  current PC; feeds adder a_in
- imem_req_out  output  1  fetch request
- imem_addr_out  output  32  fetch address; always equal to pc_out
- instr_out  output  32  fetched instruction to decode
- instr_valid_out  output  1  instr_out is valid for execution
- misaligned_out  output  1  sticky: selected next PC had [1:0] != 2'b00
- fetch_count_out  output  32  count of retired instructions

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high (rst_in); clock is clk_in.
  - All state is registered; imem_addr_out is a combinational copy of pc_out.
- Reset values:
  - pc_out = RESET_VECTOR, imem_req_out = 0, instr_out = NOP_INSTR, instr_valid_out = 0.
  - misaligned_out = 0, fetch_count_out = 0, state = BOOT.
- BOOT state:
  - One cycle with all outputs at reset values, then FETCH.
- FETCH state:
  - imem_req_out = 1, instr_valid_out = 0.
  - imem_ack_in is sampled each cycle. If it is 1, instr_out <= imem_data_in and go to ISSUE. If it is 0, stay in FETCH; req stays high and the address stays stable.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
  - branch_taken_in and stall_in are ignored in FETCH.
- ISSUE state:
  - imem_req_out = 0, instr_valid_out = 1.
  - If stall_in = 1: stay in ISSUE; pc_out, instr_out and the count are unchanged.
  - If stall_in = 0, select next = branch_taken_in ? branch_target_in : pc_plus4_in.
    - next[1:0] == 0: pc_out <= next, fetch_count_out <= fetch_count_out + 1 (wraps FFFFFFFF -> 0), instr_out <= NOP_INSTR, go to FETCH.
    - next[1:0] != 0: misaligned_out <= 1, pc_out unchanged, count unchanged, go to ERROR.
- ERROR state:
  - imem_req_out = 0, instr_valid_out = 0, instr_out = NOP_INSTR, misaligned_out = 1.
  - Exits only on reset.
- Throughput: 2 cycles per instruction minimum (FETCH + ISSUE), plus memory wait cycles.
- PC wrap-around: pc_plus4_in = 0 when pc_out = FFFFFFFC; it is accepted as a normal aligned target.
- Stray acks: imem_ack_in outside FETCH is ignored and has no side effect.
- Simultaneous stall_in and branch_taken_in in ISSUE: stall wins. The branch is re-evaluated on the first unstalled cycle using the input values present then.
- Reset mid-FETCH or mid-ISSUE: outputs return to reset values immediately, without waiting for a clock edge. A late ack after reset release is ignored unless the FSM is already in FETCH.
- Unknown state encoding: recovers to BOOT on the next clock edge.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: assert rst_in, release; ack every FETCH cycle; bench models pc_plus4_in = pc_out + 4; data = 0x00100093.
  - Required: pc_out = 0, then 4, then 8 on consecutive ISSUE exits; instr_valid_out pulses every 2nd cycle; fetch_count_out = 3 after 3 issues.
- Memory wait states:
  - Stimulus: hold imem_ack_in low for 3 cycles in FETCH.
  - Required: imem_req_out = 1 and imem_addr_out constant for 4 cycles; instr_out is loaded on the ack cycle only.
- Branch and stall:
  - Stimulus: in ISSUE at pc = 0x10, set stall_in = 1 for 2 cycles with branch_taken_in = 1 and target = 0x40, then release stall.
  - Required: pc_out holds 0x10 and instr_valid_out stays 1 during the stall; pc_out = 0x40 after release; count increments once.
- Misaligned redirect:
  - Stimulus: branch_target_in = 0x00000042, branch_taken_in = 1 in ISSUE.
  - Required: misaligned_out = 1, pc_out unchanged, imem_req_out = 0 permanently until rst_in.
- Wrap-around:
  - Stimulus: RESET_VECTOR = 0xFFFFFFFC; fetch and issue once.
  - Required: pc_out = 0x00000000, misaligned_out = 0.
  - Stimulus: force fetch_count_out to FFFFFFFF; retire one instruction.
  - Required: fetch_count_out = 0.
- Asynchronous reset:
  - Stimulus: assert rst_in mid-cycle during FETCH with a pending ack.
  - Required: imem_req_out = 0 and pc_out = RESET_VECTOR before the next clock edge; the ack is not captured.

Source files
------------

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch
//  Purpose  : Program-counter and instruction-fetch sequencer. Holds the
//             architectural PC, runs a req/ack handshake with instruction
//             memory, presents each fetched word to decode with a valid flag,
//             and selects the next PC from the PC+4 / branch-target adders.
//  Ports    : clk_in, rst_in (async, active-high)
//             pc_plus4_in, branch_target_in, branch_taken_in - next-PC sources
//             stall_in                    - hold instruction in ISSUE
//             imem_ack_in, imem_data_in   - instruction memory response
//             pc_out, imem_req_out, imem_addr_out - PC and fetch request
//             instr_out, instr_valid_out  - instruction to decode
//             misaligned_out              - sticky misaligned-target flag
//             fetch_count_out             - retired instruction count
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] pc_plus4_in,
   input  logic [31:0] branch_target_in,
   input  logic        branch_taken_in,
   input  logic        stall_in,
   input  logic        imem_ack_in,
   input  logic [31:0] imem_data_in,
   output logic [31:0] pc_out,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   output logic [31:0] instr_out,
   output logic        instr_valid_out,
   output logic        misaligned_out,
   output logic [31:0] fetch_count_out
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] count_q;
   logic        req_q;
   logic        valid_q;
   logic        mis_q;

   logic [31:0] next_pc_d;
   logic        next_ok_d;

   // Next-PC candidate and its alignment, only acted on in ISSUE.
   always_comb begin
      next_pc_d = branch_taken_in ? branch_target_in : pc_plus4_in;
      next_ok_d = (next_pc_d[1:0] == 2'b00);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VECTOR;
         instr_q <= NOP_INSTR;
         count_q <= 32'd0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         case (state_q)
            S_BOOT: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
            end
            S_FETCH: begin
               // Request and address stay stable until memory acknowledges.
               if (imem_ack_in) begin
                  state_q <= S_ISSUE;
                  instr_q <= imem_data_in;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               // Stall takes priority over any redirect; the branch inputs
               // are re-evaluated on the first unstalled cycle.
               if (!stall_in) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
                  if (next_ok_d) begin
                     state_q <= S_FETCH;
                     pc_q    <= next_pc_d;
                     count_q <= count_q + 32'd1;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     mis_q   <= 1'b1;
                     req_q   <= 1'b0;
                  end
               end
            end
            S_ERROR: begin
               // Terminal until reset.
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               instr_q <= NOP_INSTR;
               mis_q   <= 1'b1;
            end
            default: begin
               state_q <= S_BOOT;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               instr_q <= NOP_INSTR;
            end
         endcase
      end
   end

   assign pc_out          = pc_q;
   assign imem_addr_out   = pc_q;
   assign imem_req_out    = req_q;
   assign instr_out       = instr_q;
   assign instr_valid_out = valid_q;
   assign misaligned_out  = mis_q;
   assign fetch_count_out = count_q;

endmodule
`default_nettype wire
